clock_step_ctrl: RTL and testbench
==================================

Name: clock_step_ctrl

Overview:
- Run-control sequencer placed between the board clock/reset block and the CPU core.
- Owns the CPU's reset release and a per-cycle clock enable (ce), so the design can run free, run paced, halt, or single-step from board buttons.
- Replaces coarse clock division for debugging: the clock never stops; only ce gates CPU state updates.

Parameters:
- RESET_CYCLES, 16'd4095: cycles cpu_resetn is held low after resetn deasserts (BRAM settle time); must be >= 1.
- DEBOUNCE_BITS, 16: debounce counter width; an input must be stable for 2^DEBOUNCE_BITS cycles.
- SLOW_BITS, 20: paced-run divider width; ce period is 2^SLOW_BITS cycles when slow_sel=1; must be >= 1.
- START_HALTED, 0: 1 means leave INIT into HALT, 0 means leave into RUN.

Ports:
- clk, in, 1: design clock, single clock domain.
- resetn, in, 1: asynchronous active-low reset.
- run_btn, in, 1: asynchronous, active-high run/halt toggle button.
- step_btn, in, 1: asynchronous, active-high single-step button.
- halt_req, in, 1: synchronous halt request from the CPU (e.g. EBREAK).
- slow_sel, in, 1: synchronous; 1 selects paced RUN.
- cpu_resetn, out, 1: registered active-low reset to the CPU.
- ce, out, 1: CPU clock enable.
- state, out, 2: current FSM state.
- halted, out, 1: high when state==HALT.
- cycle_cnt, out, 32: count of cycles with ce=1.

Behaviour:
- Async reset (resetn=0) takes effect immediately:
  - state=INIT; init counter=0; divider=0; cycle_cnt=0.
  - cpu_resetn=0, ce=0, halted=0.
  - Debounce stable values, counters and synchronizers cleared to 0.
  - Applies mid-operation, including during STEP.
- Button path, one btn_debounce instance per button:
  - 2-FF synchronizer.
  - Counter increments while the synced value differs from the stable value and clears whenever they match.
  - When the counter reaches all-ones, the stable value takes the synced value and the counter clears.
  - press = one-cycle pulse on the rising edge of the stable value.
  - Releases and glitches shorter than 2^DEBOUNCE_BITS cycles produce no press.
- FSM encoding: INIT=2'b00, RUN=2'b01, HALT=2'b10, STEP=2'b11.
  - INIT: counter increments each cycle. At count RESET_CYCLES-1 the next state is RUN (or HALT if START_HALTED=1), and cpu_resetn registers to 1 in that same transition. Buttons and halt_req are ignored in INIT.
  - RUN: if halt_req or run_press, go to HALT next cycle; halt_req has priority when both are high, and the result is the same.
  - HALT: if run_press, go to RUN; otherwise if step_press, go to STEP (run_press wins when both are high). halt_req is ignored.
  - STEP: unconditionally go to HALT after exactly one cycle. Presses in STEP are dropped.
- ce, combinational from registers only:
  - ce = (state==RUN && (!slow_sel || div==all-ones)) || state==STEP.
  - div is a SLOW_BITS-wide free-running counter; it runs in all states except INIT and wraps.
  - In INIT and HALT, ce=0.
  - In STEP, ce=1 regardless of slow_sel.
  - In the cycle halt_req is seen in RUN, ce may still be 1 (the CPU completes that cycle); ce is 0 from the next cycle.
- cycle_cnt increments on every cycle with ce=1 and wraps from 0xFFFFFFFF to 0. It is not cleared on halt.
- halted = (state==HALT).
- Latency, run_btn press to state change: 2 sync cycles + 2^DEBOUNCE_BITS stable cycles, then the press pulse, then state updates on the following edge.

Decomposition:
- Package clockworks_pkg:
  - State encoding constants ST_INIT, ST_RUN, ST_HALT, ST_STEP.
  - The 2-bit state type.
- Sub-module btn_debounce (params: DEBOUNCE_BITS; ports: clk, resetn, btn, stable, press), instantiated twice.
- FSM, divider, init counter and cycle counter stay in clock_step_ctrl.

Test Plan (RESET_CYCLES=8, DEBOUNCE_BITS=2, SLOW_BITS=2, START_HALTED=0 unless noted):
1. Reset release: deassert resetn.
   - cpu_resetn=0 and ce=0 for exactly 8 cycles, then cpu_resetn=1, state=01, ce=1 every cycle.
   - cycle_cnt=10 after 10 RUN cycles.
2. Paced run: slow_sel=1 in RUN -> ce high 1 cycle in 4; cycle_cnt advances by 5 over 20 cycles.
3. Halt, step, run (START_HALTED=1):
   - Halted after INIT; hold step_btn 8 cycles -> exactly one ce pulse, state 11 -> 10, cycle_cnt=1.
   - Then press run_btn -> state 01.
4. Debounce:
   - 3-cycle run_btn glitch -> no state change.
   - 6-cycle hold -> exactly one toggle.
   - Simultaneous run and step press in HALT -> RUN.
5. CPU halt: pulse halt_req in RUN -> ce=0 from the next cycle, halted=1; halt_req held in HALT has no effect.
6. Mid-operation reset: assert resetn low during STEP -> same cycle ce=0, cpu_resetn=0, cycle_cnt=0, state=00; the INIT sequence repeats on release.

Source files
------------

// File: rtl/clockworks_pkg.sv
// Shared definitions for the run-control sequencer.
// Provides the 2-bit FSM state type and its encoding constants.
package clockworks_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10,
        ST_STEP = 2'b11
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, rising-edge press.
// Ports: clk, resetn (async, active-low), btn (async raw), stable, press (1-cycle).
module btn_debounce #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn,
    output logic stable,
    output logic press
);

    logic                     sync1;
    logic                     sync2;
    logic                     stable_d;
    logic [DEBOUNCE_BITS-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            // Any cycle where the input agrees with the accepted value
            // restarts the stability window.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (&cnt) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = stable & ~stable_d;

endmodule

// File: rtl/clock_step_ctrl.sv
// Run-control sequencer: CPU reset release, free/paced run, halt and step.
// Ports: clk, resetn, run_btn, step_btn, halt_req, slow_sel in;
//        cpu_resetn, ce, state, halted, cycle_cnt out.
module clock_step_ctrl
    import clockworks_pkg::*;
#(
    parameter logic [15:0] RESET_CYCLES  = 16'd4095,
    parameter int          DEBOUNCE_BITS = 16,
    parameter int          SLOW_BITS     = 20,
    parameter bit          START_HALTED  = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run_btn,
    input  logic        step_btn,
    input  logic        halt_req,
    input  logic        slow_sel,
    output logic        cpu_resetn,
    output logic        ce,
    output logic [1:0]  state,
    output logic        halted,
    output logic [31:0] cycle_cnt
);

    localparam logic [15:0] INIT_LAST = RESET_CYCLES - 16'd1;

    state_t               st_q;
    state_t               st_d;
    logic [15:0]          init_cnt;
    logic [SLOW_BITS-1:0] div;
    logic                 init_done;
    logic                 run_press;
    logic                 step_press;
    logic [1:0]           stable_unused;

    btn_debounce #(
        .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_run_db (
        .clk    (clk),
        .resetn (resetn),
        .btn    (run_btn),
        .stable (stable_unused[0]),
        .press  (run_press)
    );

    btn_debounce #(
        .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_step_db (
        .clk    (clk),
        .resetn (resetn),
        .btn    (step_btn),
        .stable (stable_unused[1]),
        .press  (step_press)
    );

    assign init_done = (init_cnt == INIT_LAST);

    // State register; cpu_resetn is released on the INIT exit edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q       <= ST_INIT;
            cpu_resetn <= 1'b0;
        end else begin
            st_q <= st_d;
            if (st_q == ST_INIT && init_done) begin
                cpu_resetn <= 1'b1;
            end
        end
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            ST_INIT: begin
                if (init_done) begin
                    st_d = START_HALTED ? ST_HALT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req || run_press) begin
                    st_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (run_press) begin
                    st_d = ST_RUN;
                end else if (step_press) begin
                    st_d = ST_STEP;
                end
            end
            ST_STEP: begin
                st_d = ST_HALT;
            end
            default: begin
                st_d = ST_INIT;
            end
        endcase
    end

    always_comb begin
        ce = 1'b0;
        unique case (st_q)
            ST_RUN:  ce = !slow_sel || (&div);
            ST_STEP: ce = 1'b1;
            default: ce = 1'b0;
        endcase
    end

    assign halted = (st_q == ST_HALT);
    assign state  = st_q;

    // Divider keeps running through HALT/STEP so pacing phase is
    // independent of when RUN is re-entered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            init_cnt  <= '0;
            div       <= '0;
            cycle_cnt <= '0;
        end else begin
            if (st_q == ST_INIT) begin
                init_cnt <= init_cnt + 16'd1;
            end else begin
                div <= div + 1'b1;
            end
            if (ce) begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Bench for clock_step_ctrl: free-run and start-halted instances share inputs.
// Outputs are compared every cycle against a behavioural model.
module tb_clock_step_ctrl;

    localparam logic [15:0] RC   = 16'd8;
    localparam int          DB   = 2;
    localparam int          SB   = 2;
    localparam int          NDB  = 1 << DB;
    localparam int          NDIV = 1 << SB;

    logic clk      = 1'b0;
    logic resetn   = 1'b0;
    logic run_btn  = 1'b0;
    logic step_btn = 1'b0;
    logic halt_req = 1'b0;
    logic slow_sel = 1'b0;

    logic        d_rn    [2];
    logic        d_ce    [2];
    logic [1:0]  d_state [2];
    logic        d_halt  [2];
    logic [31:0] d_cnt   [2];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    clock_step_ctrl #(
        .RESET_CYCLES (RC),
        .DEBOUNCE_BITS(DB),
        .SLOW_BITS    (SB),
        .START_HALTED (1'b0)
    ) u_dut_run (
        .clk        (clk),
        .resetn     (resetn),
        .run_btn    (run_btn),
        .step_btn   (step_btn),
        .halt_req   (halt_req),
        .slow_sel   (slow_sel),
        .cpu_resetn (d_rn[0]),
        .ce         (d_ce[0]),
        .state      (d_state[0]),
        .halted     (d_halt[0]),
        .cycle_cnt  (d_cnt[0])
    );

    clock_step_ctrl #(
        .RESET_CYCLES (RC),
        .DEBOUNCE_BITS(DB),
        .SLOW_BITS    (SB),
        .START_HALTED (1'b1)
    ) u_dut_halt (
        .clk        (clk),
        .resetn     (resetn),
        .run_btn    (run_btn),
        .step_btn   (step_btn),
        .halt_req   (halt_req),
        .slow_sel   (slow_sel),
        .cpu_resetn (d_rn[1]),
        .ce         (d_ce[1]),
        .state      (d_state[1]),
        .halted     (d_halt[1]),
        .cycle_cnt  (d_cnt[1])
    );

    // Behavioural model: per-instance mode/counters, shared button model.
    logic [1:0]  m_state [2];
    int          m_init  [2];
    int          m_div   [2];
    logic [31:0] m_cnt   [2];
    bit          m_p1    [2];
    bit          m_p2    [2];
    bit          m_stb   [2];
    int          m_run   [2];
    bit          m_press [2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_ce(input int i);
        return (m_state[i] == 2'b01 && (!slow_sel || m_div[i] == NDIV - 1))
               || m_state[i] == 2'b11;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 2'b00;
            m_init[i]  = 0;
            m_div[i]   = 0;
            m_cnt[i]   = 32'd0;
            m_p1[i]    = 1'b0;
            m_p2[i]    = 1'b0;
            m_stb[i]   = 1'b0;
            m_run[i]   = 0;
            m_press[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit ce_now [2];
        bit btn    [2];
        bit synced;
        if (!resetn) begin
            model_reset();
            return;
        end
        btn[0] = run_btn;
        btn[1] = step_btn;
        for (int i = 0; i < 2; i++) begin
            ce_now[i] = model_ce(i);
            if (m_state[i] != 2'b00) m_div[i] = (m_div[i] + 1) % NDIV;
            if (ce_now[i]) m_cnt[i] = m_cnt[i] + 32'd1;
            case (m_state[i])
                2'b00: begin
                    if (m_init[i] == int'(RC) - 1)
                        m_state[i] = (i == 1) ? 2'b10 : 2'b01;
                    m_init[i]++;
                end
                2'b01: if (halt_req || m_press[0]) m_state[i] = 2'b10;
                2'b10: begin
                    if (m_press[0])      m_state[i] = 2'b01;
                    else if (m_press[1]) m_state[i] = 2'b11;
                end
                default: m_state[i] = 2'b10;
            endcase
        end
        // A button is accepted after NDB consecutive differing samples
        // seen two cycles late; a press is flagged for the next cycle.
        for (int b = 0; b < 2; b++) begin
            synced     = m_p2[b];
            m_press[b] = 1'b0;
            if (synced != m_stb[b]) begin
                m_run[b]++;
                if (m_run[b] == NDB) begin
                    m_stb[b]   = synced;
                    m_run[b]   = 0;
                    m_press[b] = synced;
                end
            end else begin
                m_run[b] = 0;
            end
            m_p2[b] = m_p1[b];
            m_p1[b] = btn[b];
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("state%0d", i), 32'(d_state[i]), 32'(m_state[i]));
            check($sformatf("ce%0d", i), 32'(d_ce[i]), 32'(model_ce(i)));
            check($sformatf("cpu_rn%0d", i), 32'(d_rn[i]),
                  32'(m_state[i] != 2'b00));
            check($sformatf("halted%0d", i), 32'(d_halt[i]),
                  32'(m_state[i] == 2'b10));
            check($sformatf("cnt%0d", i), d_cnt[i], m_cnt[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic press_run(input int hold);
        run_btn = 1'b1;
        ticks(hold);
        run_btn = 1'b0;
        ticks(10);
    endtask

    int rseg;
    int sseg;

    initial begin
        model_reset();
        resetn = 1'b0;
        ticks(3);

        // Reset release and INIT window.
        resetn = 1'b1;
        ticks(7);
        check("init_rn", 32'(d_rn[0]), 32'd0);
        check("init_ce", 32'(d_ce[0]), 32'd0);
        tick();
        check("init_exit_rn", 32'(d_rn[0]), 32'd1);
        check("init_exit_st", 32'(d_state[0]), 32'd1);
        check("init_exit_h", 32'(d_state[1]), 32'd2);
        ticks(10);
        check("run10", d_cnt[0], 32'd10);

        // Paced run: one ce in four.
        slow_sel = 1'b1;
        ticks(20);
        check("paced", d_cnt[0], 32'd15);
        slow_sel = 1'b0;

        // Single step on the start-halted instance.
        step_btn = 1'b1;
        ticks(8);
        step_btn = 1'b0;
        ticks(8);
        check("step_cnt", d_cnt[1], 32'd1);
        check("step_st", 32'(d_state[1]), 32'd2);
        press_run(6);
        check("run_h", 32'(d_state[1]), 32'd1);
        check("run_r", 32'(d_state[0]), 32'd2);

        // Glitch, clean hold, simultaneous press.
        press_run(3);
        check("glitch", 32'(d_state[0]), 32'd2);
        press_run(6);
        check("hold6", 32'(d_state[0]), 32'd1);
        press_run(6);
        step_btn = 1'b1;
        press_run(6);
        step_btn = 1'b0;
        ticks(8);
        check("simul", 32'(d_state[0]), 32'd1);

        // CPU halt request.
        halt_req = 1'b1;
        tick();
        check("hreq_ce", 32'(d_ce[0]), 32'd0);
        check("hreq_h", 32'(d_halt[0]), 32'd1);
        ticks(5);
        halt_req = 1'b0;
        check("hreq_hold", 32'(d_state[0]), 32'd2);

        // Reset in the middle of a step.
        step_btn = 1'b1;
        for (int k = 0; k < 20 && m_state[0] != 2'b11; k++) tick();
        check("step_wait", 32'(d_state[0]), 32'd3);
        resetn = 1'b0;
        #1;
        check("mid_st", 32'(d_state[0]), 32'd0);
        check("mid_ce", 32'(d_ce[0]), 32'd0);
        check("mid_rn", 32'(d_rn[0]), 32'd0);
        check("mid_cnt", d_cnt[0], 32'd0);
        step_btn = 1'b0;
        @(negedge clk);
        ticks(2);
        resetn = 1'b1;
        ticks(8);
        check("reinit", 32'(d_state[0]), 32'd1);

        // Randomized traffic.
        rseg = 0;
        sseg = 0;
        for (int k = 0; k < 3000; k++) begin
            if (rseg == 0) begin
                run_btn = ($urandom % 3 == 0);
                rseg = $urandom_range(1, 9);
            end
            if (sseg == 0) begin
                step_btn = ($urandom % 3 == 0);
                sseg = $urandom_range(1, 9);
            end
            rseg--;
            sseg--;
            halt_req = ($urandom % 12 == 0);
            if ($urandom % 40 == 0) slow_sel = ~slow_sel;
            resetn = ($urandom % 600 != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
